// File: rtl/win_scoreboard.sv
// win_scoreboard
//   Two-player match scoreboard for the tug-of-war playfield. It keeps a score
//   per player and scores one point for each press edge, not for each cycle a
//   button is held. After a point it pulses a one-cycle round restart and then
//   ignores both buttons for HOLDOFF cycles. The first player to reach
//   MAX_SCORE wins, and the match then stays frozen until newGame or reset.
//
// Ports
//   i_clk           system clock, all state on posedge
//   i_rst_n         asynchronous active-low reset
//   i_l / i_r       left / right player buttons (synchronised levels)
//   i_left_light    leftmost playfield light lit
//   i_right_light   rightmost playfield light lit
//   i_new_game      synchronous clear of scores and winner
//   o_hex_left      seven-segment digit {g,f,e,d,c,b,a}, left score
//   o_hex_right     seven-segment digit {g,f,e,d,c,b,a}, right score
//   o_round_reset   one-cycle pulse restarting the playfield light chain
//   o_game_over     high while the match is over
//   o_win_left      high while over, if the left player won
//   o_win_right     high while over, if the right player won

// Decimal seven-segment decoder; codes above 9 blank the digit.
module win_seg7 #(
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);
    logic [6:0] w_on;   // active-high pattern, {g,f,e,d,c,b,a}

    always_comb begin
        w_on = 7'b0000000;
        case (i_code)
            4'd0: w_on = 7'b0111111;
            4'd1: w_on = 7'b0000110;
            4'd2: w_on = 7'b1011011;
            4'd3: w_on = 7'b1001111;
            4'd4: w_on = 7'b1100110;
            4'd5: w_on = 7'b1101101;
            4'd6: w_on = 7'b1111101;
            4'd7: w_on = 7'b0000111;
            4'd8: w_on = 7'b1111111;
            4'd9: w_on = 7'b1101111;
            default: w_on = 7'b0000000;
        endcase
    end

    assign o_seg = SEG_ACT_LOW ? ~w_on : w_on;
endmodule

module win_scoreboard #(
    parameter int MAX_SCORE   = 7,     // 1..9
    parameter int HOLDOFF     = 4,     // 1..255
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_l,
    input  logic       i_r,
    input  logic       i_left_light,
    input  logic       i_right_light,
    input  logic       i_new_game,
    output logic [6:0] o_hex_left,
    output logic [6:0] o_hex_right,
    output logic       o_round_reset,
    output logic       o_game_over,
    output logic       o_win_left,
    output logic       o_win_right
);
    localparam int            SW        = $clog2(MAX_SCORE + 1);
    localparam logic [SW-1:0] MAX_S     = SW'(MAX_SCORE);
    localparam logic [7:0]    HOLD_INIT = 8'(HOLDOFF - 1);

    typedef enum logic [1:0] {PLAY, HOLD, OVER} state_t;

    state_t        r_state;
    logic [SW-1:0] r_score_l, r_score_r;
    logic          r_l_q, r_r_q;
    logic [7:0]    r_hold_cnt;
    logic          r_round_reset, r_game_over, r_win_left, r_win_right;

    // A point needs a fresh edge, the opponent's button released, and the
    // light on the scorer's side lit. Both buttons high blocks both sides.
    logic          w_pt_l, w_pt_r;
    logic [SW-1:0] w_nxt_l, w_nxt_r;

    assign w_pt_l  = i_l & ~r_l_q & ~i_r & i_left_light;
    assign w_pt_r  = i_r & ~r_r_q & ~i_l & i_right_light;
    assign w_nxt_l = r_score_l + SW'(1);
    assign w_nxt_r = r_score_r + SW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= PLAY;
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_l_q         <= 1'b0;
            r_r_q         <= 1'b0;
            r_hold_cnt    <= 8'd0;
            r_round_reset <= 1'b0;
            r_game_over   <= 1'b0;
            r_win_left    <= 1'b0;
            r_win_right   <= 1'b0;
        end else begin
            // Edge history runs in every state, so a button held through
            // HOLD is already "old" when PLAY resumes.
            r_l_q         <= i_l;
            r_r_q         <= i_r;
            r_round_reset <= 1'b0;
            if (i_new_game) begin
                r_state     <= PLAY;
                r_score_l   <= '0;
                r_score_r   <= '0;
                r_hold_cnt  <= 8'd0;
                r_game_over <= 1'b0;
                r_win_left  <= 1'b0;
                r_win_right <= 1'b0;
            end else begin
                case (r_state)
                    PLAY: begin
                        if (w_pt_l) begin
                            r_score_l     <= w_nxt_l;
                            r_round_reset <= 1'b1;
                            if (w_nxt_l == MAX_S) begin
                                r_state     <= OVER;
                                r_game_over <= 1'b1;
                                r_win_left  <= 1'b1;
                            end else begin
                                r_state    <= HOLD;
                                r_hold_cnt <= HOLD_INIT;
                            end
                        end else if (w_pt_r) begin
                            r_score_r     <= w_nxt_r;
                            r_round_reset <= 1'b1;
                            if (w_nxt_r == MAX_S) begin
                                r_state     <= OVER;
                                r_game_over <= 1'b1;
                                r_win_right <= 1'b1;
                            end else begin
                                r_state    <= HOLD;
                                r_hold_cnt <= HOLD_INIT;
                            end
                        end
                    end
                    HOLD: begin
                        if (r_hold_cnt == 8'd0) r_state <= PLAY;
                        else                    r_hold_cnt <= r_hold_cnt - 8'd1;
                    end
                    OVER:    r_state <= OVER;
                    default: r_state <= PLAY;
                endcase
            end
        end
    end

    // Digit 1 is the left player, digit 0 the right player.
    logic [1:0][3:0] w_code;
    logic [1:0][6:0] w_seg;

    assign w_code[1] = 4'(r_score_l);
    assign w_code[0] = 4'(r_score_r);

    for (genvar g = 0; g < 2; g++) begin : g_seg
        win_seg7 #(.SEG_ACT_LOW(SEG_ACT_LOW)) u_seg (
            .i_code (w_code[g]),
            .o_seg  (w_seg[g])
        );
    end

    assign o_hex_left    = w_seg[1];
    assign o_hex_right   = w_seg[0];
    assign o_round_reset = r_round_reset;
    assign o_game_over   = r_game_over;
    assign o_win_left    = r_win_left;
    assign o_win_right   = r_win_right;
endmodule

// File: tb/tb_win_scoreboard.sv
module tb_win_scoreboard;
    logic clk = 1'b0, rst_n = 1'b0;
    logic l = 1'b0, r = 1'b0, ll = 1'b0, rl = 1'b0, ng = 1'b0;
    logic [6:0] hex_l, hex_r;
    logic rr, go, wl, wr;

    win_scoreboard #(.MAX_SCORE(7), .HOLDOFF(4), .SEG_ACT_LOW(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_l(l), .i_r(r),
        .i_left_light(ll), .i_right_light(rl), .i_new_game(ng),
        .o_hex_left(hex_l), .o_hex_right(hex_r), .o_round_reset(rr),
        .o_game_over(go), .o_win_left(wl), .o_win_right(wr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] hl, hr;
        logic rr, go, wl, wr;
    } out_t;

    typedef struct packed {
        logic l, r, ll, rl, ng;
        out_t exp;
    } vec_t;

    // Active-low digits 0..9
    logic [6:0] hx [0:9];
    out_t exp_q [$];
    vec_t tbl [$];
    int n_chk = 0, n_pass = 0;
    out_t act;
    assign act = {hex_l, hex_r, rr, go, wl, wr};

    function automatic out_t mko(logic [6:0] hl, logic [6:0] hr, logic prr, logic pgo, logic pwl, logic pwr);
        out_t o;
        o = {hl, hr, prr, pgo, pwl, pwr};
        return o;
    endfunction

    function automatic vec_t mkv(logic pl, logic pr, logic pll, logic prl, logic png, out_t e);
        vec_t v;
        v = {pl, pr, pll, prl, png, e};
        return v;
    endfunction

    task automatic check(string name, out_t want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got hexL=%b hexR=%b rr=%b go=%b wl=%b wr=%b, required hexL=%b hexR=%b rr=%b go=%b wl=%b wr=%b",
                      name, act.hl, act.hr, act.rr, act.go, act.wl, act.wr,
                      want.hl, want.hr, want.rr, want.go, want.wl, want.wr);
    endtask

    // Drive on negedge, queue the expectation, compare just after the edge.
    task automatic step(string name, logic pl, logic pr, logic pll, logic prl, logic png, out_t want);
        out_t e;
        @(negedge clk);
        l = pl; r = pr; ll = pll; rl = prl; ng = png;
        exp_q.push_back(want);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, e);
    endtask

    initial begin
        hx[0] = 7'b1000000; hx[1] = 7'b1111001; hx[2] = 7'b0100100; hx[3] = 7'b0110000;
        hx[4] = 7'b0011001; hx[5] = 7'b0010010; hx[6] = 7'b0000010; hx[7] = 7'b1111000;
        hx[8] = 7'b0000000; hx[9] = 7'b0010000;

        // Idle, hold-to-score once, simultaneous press, hold-off rejection.
        tbl.push_back(mkv(0, 0, 0, 0, 0, mko(hx[0], hx[0], 0, 0, 0, 0)));
        tbl.push_back(mkv(1, 0, 1, 0, 0, mko(hx[1], hx[0], 1, 0, 0, 0)));
        for (int i = 0; i < 9; i++)
            tbl.push_back(mkv(1, 0, 1, 0, 0, mko(hx[1], hx[0], 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 1, 0, 0, mko(hx[1], hx[0], 0, 0, 0, 0)));
        tbl.push_back(mkv(1, 1, 1, 1, 0, mko(hx[1], hx[0], 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 1, 1, 0, mko(hx[1], hx[0], 0, 0, 0, 0)));
        tbl.push_back(mkv(1, 0, 1, 0, 0, mko(hx[2], hx[0], 1, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 1, 0, 0, mko(hx[2], hx[0], 0, 0, 0, 0)));
        tbl.push_back(mkv(1, 0, 1, 0, 0, mko(hx[2], hx[0], 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 1, 0, 0, mko(hx[2], hx[0], 0, 0, 0, 0)));
        tbl.push_back(mkv(0, 0, 1, 0, 0, mko(hx[2], hx[0], 0, 0, 0, 0)));
        tbl.push_back(mkv(1, 0, 1, 0, 0, mko(hx[3], hx[0], 1, 0, 0, 0)));

        #12;
        check("reset_state", mko(hx[0], hx[0], 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i].l, tbl[i].r, tbl[i].ll, tbl[i].rl, tbl[i].ng, tbl[i].exp);

        // Reset in the middle of HOLD at scoreL=3 clears without an edge.
        step("hold_before_rst", 0, 0, 1, 0, 0, mko(hx[3], hx[0], 0, 0, 0, 0));
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_hold", mko(hx[0], hx[0], 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // Right player runs the match to 7.
        for (int k = 1; k <= 7; k++) begin
            step($sformatf("r_pt%0d", k), 0, 1, 0, 1, 0,
                 mko(hx[0], hx[k], 1, k == 7, 0, k == 7));
            for (int j = 0; j < 4; j++)
                step($sformatf("r_gap%0d_%0d", k, j), 0, 0, 0, 1, 0,
                     mko(hx[0], hx[k], 0, k == 7, 0, k == 7));
        end
        step("over_press_r", 0, 1, 0, 1, 0, mko(hx[0], hx[7], 0, 1, 0, 1));
        step("over_press_l", 1, 0, 1, 1, 0, mko(hx[0], hx[7], 0, 1, 0, 1));

        // newGame out of OVER, then newGame beating a valid point in PLAY.
        step("ng_over", 1, 0, 1, 1, 1, mko(hx[0], hx[0], 0, 0, 0, 0));
        step("ng_idle", 0, 0, 0, 1, 0, mko(hx[0], hx[0], 0, 0, 0, 0));
        step("ng_r_pt", 0, 1, 0, 1, 0, mko(hx[0], hx[1], 1, 0, 0, 0));
        for (int j = 0; j < 4; j++)
            step($sformatf("ng_gap%0d", j), 0, 0, 0, 1, 0, mko(hx[0], hx[1], 0, 0, 0, 0));
        step("ng_prio", 1, 0, 1, 0, 1, mko(hx[0], hx[0], 0, 0, 0, 0));
        step("ng_rel", 0, 0, 1, 0, 0, mko(hx[0], hx[0], 0, 0, 0, 0));
        step("ng_l_pt", 1, 0, 1, 0, 0, mko(hx[1], hx[0], 1, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
